iw_fetch_queue: RTL and testbench

- Parametrised successor of the single-slot instruction-wait stage, sitting between IF (request issue) and ID.
- Tracks up to DEPTH in-order instruction fetches outstanding on the sram-like bus and buffers the returned instructions.
- Presents returned instructions to ID in program order with their PC and exception info.
- On flush, drops all entries and counts stale bus responses so they are discarded, so no response is ever delivered to the wrong PC.

---
 rtl/iw_fetch_queue_if.sv | 52 +++++
 rtl/iw_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_iw_fetch_queue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iw_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : iw_fetch_queue_if
// Brief   : IF request, bus response, flush and ID handshake bundle
// Revision: 1.0 - initial release
// ============================================================================
interface iw_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int DW = $clog2(DEPTH) + 1;

  // IF side
  logic              req_fire;
  logic [PC_W-1:0]   req_pc;
  logic              req_exc;
  logic [5:0]        req_ecode;
  logic [8:0]        req_esubcode;
  logic              req_allow;

  // bus response and pipeline flush
  logic              data_ok;
  logic [INST_W-1:0] rdata;
  logic              flush;

  // ID side
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_exc;
  logic [5:0]        out_ecode;
  logic [8:0]        out_esubcode;

  logic [DW-1:0]     discard_cnt;

  modport master (
    output req_fire, req_pc, req_exc, req_ecode, req_esubcode,
    output data_ok, rdata, flush, out_ready,
    input  req_allow, out_valid, out_pc, out_inst, out_exc,
    input  out_ecode, out_esubcode, discard_cnt
  );

  modport slave (
    input  req_fire, req_pc, req_exc, req_ecode, req_esubcode,
    input  data_ok, rdata, flush, out_ready,
    output req_allow, out_valid, out_pc, out_inst, out_exc,
    output out_ecode, out_esubcode, discard_cnt
  );
endinterface
`default_nettype wire

// File: rtl/iw_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : iw_fetch_queue
// Brief   : In-order instruction-wait queue between IF and ID with flush
//           accounting of stale bus responses
// Revision: 1.0 - initial release
// ============================================================================
module iw_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input wire               clk,
  input wire               rst,
  iw_fetch_queue_if.slave  fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [AW:0]   c_depth_cnt = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] c_depth_out = (AW+2)'(DEPTH);

  // entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_filled;
  logic [DEPTH-1:0]  r_exc;
  logic [PC_W-1:0]   r_pc     [DEPTH];
  logic [INST_W-1:0] r_inst   [DEPTH];
  logic [5:0]        r_ecode  [DEPTH];
  logic [8:0]        r_esub   [DEPTH];

  logic [AW:0]       r_head;
  logic [AW:0]       r_tail;
  logic [DW-1:0]     r_discard;

  logic [AW-1:0]     w_head_idx;
  logic [AW-1:0]     w_tail_idx;
  logic [AW:0]       w_count;
  logic [AW:0]       w_pending;
  logic [AW+1:0]     w_outstanding;
  logic [AW+1:0]     w_flush_sum;
  logic [AW+1:0]     w_flush_next;
  logic              w_allow;
  logic              w_alloc;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_fill_hit;
  logic [AW-1:0]     w_fill_idx;

  function automatic logic [AW-1:0] f_slot(input logic [AW-1:0] base, input int k);
    return base + AW'(k);
  endfunction

  assign w_head_idx = r_head[AW-1:0];
  assign w_tail_idx = r_tail[AW-1:0];
  assign w_count    = r_tail - r_head;

  always_comb begin
    w_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pending = w_pending + (AW+1)'(r_valid[k] & ~r_filled[k]);
    end
  end

  // Responses return in issue order, so the oldest unfilled entry owns the next one.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_fill_hit && r_valid[f_slot(w_head_idx, k)] && !r_filled[f_slot(w_head_idx, k)]) begin
        w_fill_hit = 1'b1;
        w_fill_idx = f_slot(w_head_idx, k);
      end
    end
  end

  assign w_outstanding = (AW+2)'(w_pending) + (AW+2)'(r_discard);
  assign w_allow       = !rst && !fq.flush && (w_count < c_depth_cnt) && (w_outstanding < c_depth_out);
  assign w_alloc       = fq.req_fire && w_allow;

  assign w_out_valid = r_valid[w_head_idx] && r_filled[w_head_idx] && !fq.flush;
  assign w_pop       = w_out_valid && fq.out_ready;

  // Every in-flight request at flush time, including one issued this cycle, comes back stale.
  assign w_flush_sum  = w_outstanding + (AW+2)'(fq.req_fire && !fq.req_exc);
  assign w_flush_next = (fq.data_ok && (w_flush_sum != '0)) ? (w_flush_sum - 1'b1) : w_flush_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_filled  <= '0;
      r_exc     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_discard <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]    <= '0;
        r_inst[k]  <= '0;
        r_ecode[k] <= '0;
        r_esub[k]  <= '0;
      end
    end else if (fq.flush) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_discard <= DW'(w_flush_next);
    end else begin
      if (fq.data_ok) begin
        if (r_discard != '0) begin
          r_discard <= r_discard - 1'b1;
        end else if (w_fill_hit) begin
          r_filled[w_fill_idx] <= 1'b1;
          r_inst[w_fill_idx]   <= fq.rdata;
        end
      end

      if (w_pop) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + 1'b1;
      end

      // A non-full queue never has its tail slot equal to a live head or fill target.
      if (w_alloc) begin
        r_valid[w_tail_idx]  <= 1'b1;
        r_filled[w_tail_idx] <= fq.req_exc;
        r_exc[w_tail_idx]    <= fq.req_exc;
        r_pc[w_tail_idx]     <= fq.req_pc;
        r_inst[w_tail_idx]   <= '0;
        r_ecode[w_tail_idx]  <= fq.req_ecode;
        r_esub[w_tail_idx]   <= fq.req_esubcode;
        r_tail               <= r_tail + 1'b1;
      end
    end
  end

  assign fq.req_allow    = w_allow;
  assign fq.out_valid    = w_out_valid;
  assign fq.out_pc       = r_pc[w_head_idx];
  assign fq.out_inst     = r_inst[w_head_idx];
  assign fq.out_exc      = r_exc[w_head_idx];
  assign fq.out_ecode    = r_ecode[w_head_idx];
  assign fq.out_esubcode = r_esub[w_head_idx];
  assign fq.discard_cnt  = r_discard;

endmodule
`default_nettype wire

// File: tb/tb_iw_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_iw_fetch_queue
// Brief   : Scoreboard bench: bus/queue reference model plus output monitor
// Revision: 1.0 - initial release
// ============================================================================
module tb_iw_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iw_fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) fq ();

  iw_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  // expected ID-side entry; ready_at is the first cycle it may be presented
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    int          id;
    int          ready_at;
  } exp_t;

  // one in-flight bus transaction; stale ones belong to flushed fetches
  typedef struct {
    logic [31:0] rdata;
    int          id;
    bit          stale;
  } txn_t;

  exp_t exp_q[$];
  txn_t bus_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   next_id  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int stale_cnt();
    int n;
    n = 0;
    foreach (bus_q[i]) if (bus_q[i].stale) n++;
    return n;
  endfunction

  function automatic bit can_fire();
    return (exp_q.size() < DEPTH) && (bus_q.size() < DEPTH);
  endfunction

  // monitor: compares every presented/accepted head against the scoreboard
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (!rst) begin
      ev = (exp_q.size() > 0) && (exp_q[0].ready_at <= cyc) && !fq.flush;
      chk("out_valid", 64'(fq.out_valid), 64'(ev));
      if (fq.out_valid && fq.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_pc", 64'(fq.out_pc), 64'hffff_ffff_ffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc",       64'(fq.out_pc),       64'(e.pc));
          chk("out_inst",     64'(fq.out_inst),     64'(e.inst));
          chk("out_exc",      64'(fq.out_exc),      64'(e.exc));
          chk("out_ecode",    64'(fq.out_ecode),    64'(e.ecode));
          chk("out_esubcode", 64'(fq.out_esubcode), 64'(e.esub));
        end
      end
    end
  end

  // one clock of stimulus; entered and left 1 time unit after a rising edge
  task automatic step(input bit fire, input logic [31:0] pc, input bit exc,
                      input logic [5:0] ec, input logic [8:0] esc,
                      input bit dok, input bit rdy, input bit fl);
    bit          allow_m;
    bit          dok_eff;
    logic [31:0] rd;
    exp_t        e;
    txn_t        t;
    allow_m = !fl && can_fire();
    dok_eff = dok && (bus_q.size() > 0);
    rd      = $urandom();
    fq.req_fire     = fire;
    fq.req_pc       = pc;
    fq.req_exc      = exc;
    fq.req_ecode    = ec;
    fq.req_esubcode = esc;
    fq.data_ok      = dok_eff;
    fq.rdata        = dok_eff ? bus_q[0].rdata : $urandom();
    fq.out_ready    = rdy;
    fq.flush        = fl;
    #1;
    chk("req_allow",   64'(fq.req_allow),   64'(allow_m));
    chk("discard_cnt", 64'(fq.discard_cnt), 64'(stale_cnt()));
    if (dok_eff) begin
      t = bus_q.pop_front();
      if (!t.stale) foreach (exp_q[i]) if (exp_q[i].id == t.id) exp_q[i].ready_at = cyc + 1;
    end
    if (fl) begin
      exp_q.delete();
      foreach (bus_q[i]) bus_q[i].stale = 1'b1;
      if (fire && !exc) begin
        t.rdata = rd; t.id = -1; t.stale = 1'b1;
        bus_q.push_back(t);
      end
    end else if (fire && allow_m) begin
      e.pc = pc; e.inst = exc ? 32'h0 : rd; e.exc = exc; e.ecode = ec; e.esub = esc;
      e.id = next_id; e.ready_at = exc ? cyc + 1 : 32'h7fff_ffff;
      exp_q.push_back(e);
      if (!exc) begin
        t.rdata = rd; t.id = next_id; t.stale = 1'b0;
        bus_q.push_back(t);
      end
      next_id++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit dok, input bit rdy);
    step(1'b0, 32'h0, 1'b0, 6'h0, 9'h0, dok, rdy, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit rdy);
    step(1'b1, pc, 1'b0, 6'h0, 9'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || bus_q.size() > 0) && k < budget) begin
      idle(1'b1, 1'b1);
      k++;
    end
    chk("drain_left", 64'(exp_q.size() + bus_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq.req_fire = 1'b0; fq.req_pc = '0; fq.req_exc = 1'b0; fq.req_ecode = '0;
    fq.req_esubcode = '0; fq.data_ok = 1'b0; fq.rdata = '0; fq.flush = 1'b0;
    fq.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    bus_q.delete();
    chk("rst_out_valid",    64'(fq.out_valid),    64'd0);
    chk("rst_req_allow",    64'(fq.req_allow),    64'd0);
    chk("rst_discard_cnt",  64'(fq.discard_cnt),  64'd0);
    chk("rst_out_pc",       64'(fq.out_pc),       64'd0);
    chk("rst_out_inst",     64'(fq.out_inst),     64'd0);
    chk("rst_out_exc",      64'(fq.out_exc),      64'd0);
    chk("rst_out_ecode",    64'(fq.out_ecode),    64'd0);
    chk("rst_out_esubcode", 64'(fq.out_esubcode), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int          issued;
    bit          f, ex, fl;
    logic [5:0]  ec;
    logic [8:0]  esc;

    do_reset();

    // back-to-back fetches, queue refuses a fifth, responses a cycle apart
    for (int i = 0; i < 4; i++) fetch(32'h1c00_0000 + 32'(4 * i), 1'b1);
    fetch(32'h1c00_0010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b1);
      idle(1'b0, 1'b1);
    end
    drain(20);

    // backpressure with a full, fully returned queue
    for (int i = 0; i < 4; i++) fetch(32'h1c00_0000 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);
    drain(20);

    // flush with three pending plus a same-cycle fetch
    for (int i = 0; i < 3; i++) fetch(32'h1c00_0020 + 32'(4 * i), 1'b1);
    step(1'b1, 32'h1c00_002c, 1'b0, 6'h0, 9'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
    fetch(32'h1c00_0100, 1'b1);
    drain(20);

    // flush coincident with a response, two pending
    for (int i = 0; i < 2; i++) fetch(32'h1c00_0040 + 32'(4 * i), 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 9'h0, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    drain(20);

    // exception entry queued behind a pending fetch
    fetch(32'h1c00_0000, 1'b1);
    step(1'b1, 32'h1c00_0004, 1'b1, 6'h08, 9'h000, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    drain(20);

    // sequential wrap-around with random response and accept timing
    pc = 32'h1c00_0200;
    issued = 0;
    for (int c = 0; c < 400 && (issued < 3 * DEPTH || exp_q.size() > 0 || bus_q.size() > 0); c++) begin
      f = (issued < 3 * DEPTH) && can_fire() && ($urandom_range(0, 3) != 0);
      step(f, pc, 1'b0, 6'h0, 9'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b0);
      if (f) begin
        pc = pc + 32'd4;
        issued++;
      end
    end
    chk("wrap_issued", 64'(issued), 64'(3 * DEPTH));
    drain(20);

    // random traffic with flushes, exceptions, refused fetches and a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      fl = ($urandom_range(0, 39) == 0);
      f  = ($urandom_range(0, 9) < 6);
      if (fl && bus_q.size() >= DEPTH) f = 1'b0;
      ex  = ($urandom_range(0, 7) == 0);
      ec  = ex ? 6'($urandom()) : 6'h0;
      esc = ex ? 9'($urandom()) : 9'h0;
      step(f, {12'h1c0, 18'($urandom()), 2'b00}, ex, ec, esc,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), fl);
    end
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
